// File: rtl/alu_arbiter_if.sv
// Bundle of two requester ports, the shared-ALU operand/result path and
// the response bus between the requesters and alu_arbiter.
interface alu_arbiter_if #(parameter int DATA_W = 32);
  logic              req0_valid;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic [3:0]        req0_aluc;
  logic              req0_ready;

  logic              req1_valid;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic [3:0]        req1_aluc;
  logic              req1_ready;

  logic              flush;

  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [3:0]        alu_aluc;
  logic [DATA_W-1:0] alu_result;

  logic [DATA_W-1:0] resp_result;
  logic              resp0_valid;
  logic              resp1_valid;

  modport master (
    output req0_valid, req0_a, req0_b, req0_aluc,
    output req1_valid, req1_a, req1_b, req1_aluc,
    output flush, alu_result,
    input  req0_ready, req1_ready,
    input  alu_a, alu_b, alu_aluc,
    input  resp_result, resp0_valid, resp1_valid
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_aluc,
    input  req1_valid, req1_a, req1_b, req1_aluc,
    input  flush, alu_result,
    output req0_ready, req1_ready,
    output alu_a, alu_b, alu_aluc,
    output resp_result, resp0_valid, resp1_valid
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters:
// stage 1 registers the granted operands, stage 2 registers the result.
module alu_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  alu_arbiter_if.slave  bus
);

  logic              grant_any;
  logic              grant_id;
  logic              last_grant;
  logic              s1_valid;
  logic              s1_id;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic [3:0]        sel_aluc;

  // On a tie the requester that lost the previous acceptance wins.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = 1'b0;
    if (!rst && !bus.flush) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant_any = 1'b1;
        grant_id  = ~last_grant;
      end else if (bus.req0_valid) begin
        grant_any = 1'b1;
        grant_id  = 1'b0;
      end else if (bus.req1_valid) begin
        grant_any = 1'b1;
        grant_id  = 1'b1;
      end
    end
  end

  assign bus.req0_ready = grant_any && !grant_id;
  assign bus.req1_ready = grant_any &&  grant_id;

  assign sel_a    = grant_id ? bus.req1_a    : bus.req0_a;
  assign sel_b    = grant_id ? bus.req1_b    : bus.req0_b;
  assign sel_aluc = grant_id ? bus.req1_aluc : bus.req0_aluc;

  // Stage 1: operands to the shared ALU
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.alu_a    <= '0;
      bus.alu_b    <= '0;
      bus.alu_aluc <= 4'b0000;
      s1_valid     <= 1'b0;
      s1_id        <= 1'b0;
      last_grant   <= 1'b1;
    end else begin
      s1_valid <= grant_any;
      if (grant_any) begin
        bus.alu_a    <= sel_a;
        bus.alu_b    <= sel_b;
        bus.alu_aluc <= sel_aluc;
        s1_id        <= grant_id;
        last_grant   <= grant_id;
      end
    end
  end

  // Stage 2: result capture and response pulse; flush kills the stage-1 op
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.resp_result <= '0;
      bus.resp0_valid <= 1'b0;
      bus.resp1_valid <= 1'b0;
    end else if (s1_valid && !bus.flush) begin
      bus.resp_result <= bus.alu_result;
      bus.resp0_valid <= !s1_id;
      bus.resp1_valid <= s1_id;
    end else begin
      bus.resp0_valid <= 1'b0;
      bus.resp1_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a cycle-by-cycle vector table plus
// hand-written async-reset and streaming sequences.
module tb_alu_arbiter;

  logic clk;
  logic rst;
  int   total;
  int   passed;

  alu_arbiter_if #(.DATA_W(32)) bus ();

  alu_arbiter #(.DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU stand-in: 0000 add, 0001 and, 0010 or, 0100 sub, others xor
  always_comb begin
    case (bus.alu_aluc)
      4'b0000: bus.alu_result = bus.alu_a + bus.alu_b;
      4'b0001: bus.alu_result = bus.alu_a & bus.alu_b;
      4'b0010: bus.alu_result = bus.alu_a | bus.alu_b;
      4'b0100: bus.alu_result = bus.alu_a - bus.alu_b;
      default: bus.alu_result = bus.alu_a ^ bus.alu_b;
    endcase
  end

  typedef struct {
    logic        v0;
    logic [31:0] a0;
    logic [31:0] b0;
    logic [3:0]  c0;
    logic        v1;
    logic [31:0] a1;
    logic [31:0] b1;
    logic [3:0]  c1;
    logic        fl;
    logic        r0;
    logic        r1;
    logic        p0;
    logic        p1;
    logic [31:0] res;
    logic [31:0] alu_a;
    logic [3:0]  aluc;
  } vec_t;

  localparam logic Y = 1'b1;
  localparam logic N = 1'b0;
  localparam int NV = 19;
  vec_t tbl [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic drive_idle();
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_aluc = '0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_aluc = '0;
    bus.flush      = 1'b0;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    // v0 a0 b0 c0 | v1 a1 b1 c1 | flush | rdy0 rdy1 resp0 resp1 | resp_result alu_a alu_aluc
    tbl[0]  = '{Y, 32'd10, 32'd4, 4'h4, Y, 32'hF0, 32'h3C, 4'h1, N, Y, N, N, N, 32'h0,  32'h0,  4'h0};
    tbl[1]  = '{Y, 32'd10, 32'd4, 4'h4, Y, 32'hF0, 32'h3C, 4'h1, N, N, Y, N, N, 32'h0,  32'd10, 4'h4};
    tbl[2]  = '{Y, 32'd10, 32'd4, 4'h4, Y, 32'hF0, 32'h3C, 4'h1, N, Y, N, Y, N, 32'h6,  32'hF0, 4'h1};
    tbl[3]  = '{Y, 32'd10, 32'd4, 4'h4, Y, 32'hF0, 32'h3C, 4'h1, N, N, Y, N, Y, 32'h30, 32'd10, 4'h4};
    tbl[4]  = '{N, 32'h0, 32'h0, 4'h0, N, 32'h0, 32'h0, 4'h0, N, N, N, Y, N, 32'h6,  32'hF0, 4'h1};
    tbl[5]  = '{Y, 32'd5, 32'd3, 4'h0, N, 32'h0, 32'h0, 4'h0, N, Y, N, N, Y, 32'h30, 32'hF0, 4'h1};
    tbl[6]  = '{N, 32'h0, 32'h0, 4'h0, N, 32'h0, 32'h0, 4'h0, N, N, N, N, N, 32'h30, 32'd5,  4'h0};
    tbl[7]  = '{N, 32'h0, 32'h0, 4'h0, Y, 32'h0F, 32'h01, 4'h2, N, N, Y, Y, N, 32'h8, 32'd5,  4'h0};
    tbl[8]  = '{Y, 32'd7, 32'd2, 4'h4, Y, 32'h0F, 32'h01, 4'h2, N, Y, N, N, N, 32'h8,  32'h0F, 4'h2};
    tbl[9]  = '{N, 32'h0, 32'h0, 4'h0, Y, 32'h0F, 32'h01, 4'h2, N, N, Y, N, Y, 32'h0F, 32'd7,  4'h4};
    tbl[10] = '{N, 32'h0, 32'h0, 4'h0, N, 32'h0, 32'h0, 4'h0, N, N, N, Y, N, 32'h5,  32'h0F, 4'h2};
    tbl[11] = '{N, 32'h0, 32'h0, 4'h0, N, 32'h0, 32'h0, 4'h0, N, N, N, N, Y, 32'h0F, 32'h0F, 4'h2};
    tbl[12] = '{N, 32'h0, 32'h0, 4'h0, Y, 32'h33, 32'h11, 4'h3, N, N, Y, N, N, 32'h0F, 32'h0F, 4'h2};
    tbl[13] = '{Y, 32'd9, 32'd9, 4'h0, Y, 32'h33, 32'h11, 4'h3, Y, N, N, N, N, 32'h0F, 32'h33, 4'h3};
    tbl[14] = '{Y, 32'd9, 32'd9, 4'h0, Y, 32'h33, 32'h11, 4'h3, N, Y, N, N, N, 32'h0F, 32'h33, 4'h3};
    tbl[15] = '{N, 32'h0, 32'h0, 4'h0, N, 32'h0, 32'h0, 4'h0, N, N, N, N, N, 32'h0F, 32'd9,  4'h0};
    tbl[16] = '{Y, 32'hDEAD0000, 32'h0000BEEF, 4'hF, N, 32'h0, 32'h0, 4'h0, N, Y, N, Y, N, 32'h12, 32'd9, 4'h0};
    tbl[17] = '{N, 32'h0, 32'h0, 4'h0, N, 32'h0, 32'h0, 4'h0, N, N, N, N, N, 32'h12, 32'hDEAD0000, 4'hF};
    tbl[18] = '{N, 32'h0, 32'h0, 4'h0, N, 32'h0, 32'h0, 4'h0, N, N, N, Y, N, 32'hDEADBEEF, 32'hDEAD0000, 4'hF};

    // Reset state, with both requesters asking: ready must stay low
    rst = 1'b1;
    drive_idle();
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_alu_a",    bus.alu_a, 32'h0);
    chk("rst_alu_b",    bus.alu_b, 32'h0);
    chk("rst_aluc",     32'(bus.alu_aluc), 32'h0);
    chk("rst_result",   bus.resp_result, 32'h0);
    chk("rst_resp0",    32'(bus.resp0_valid), 32'h0);
    chk("rst_resp1",    32'(bus.resp1_valid), 32'h0);
    chk("rst_ready0",   32'(bus.req0_ready), 32'h0);
    chk("rst_ready1",   32'(bus.req1_ready), 32'h0);

    // Table: tie after reset, single op, round-robin memory, flush, opaque aluc
    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      rst            = 1'b0;
      bus.req0_valid = tbl[i].v0; bus.req0_a = tbl[i].a0; bus.req0_b = tbl[i].b0; bus.req0_aluc = tbl[i].c0;
      bus.req1_valid = tbl[i].v1; bus.req1_a = tbl[i].a1; bus.req1_b = tbl[i].b1; bus.req1_aluc = tbl[i].c1;
      bus.flush      = tbl[i].fl;
      @(negedge clk);
      chk($sformatf("v%0d_ready0", i), 32'(bus.req0_ready), 32'(tbl[i].r0));
      chk($sformatf("v%0d_ready1", i), 32'(bus.req1_ready), 32'(tbl[i].r1));
      chk($sformatf("v%0d_resp0", i),  32'(bus.resp0_valid), 32'(tbl[i].p0));
      chk($sformatf("v%0d_resp1", i),  32'(bus.resp1_valid), 32'(tbl[i].p1));
      chk($sformatf("v%0d_result", i), bus.resp_result, tbl[i].res);
      chk($sformatf("v%0d_alu_a", i),  bus.alu_a, tbl[i].alu_a);
      chk($sformatf("v%0d_aluc", i),   32'(bus.alu_aluc), 32'(tbl[i].aluc));
    end

    // Async reset with an op sitting in stage 1
    @(posedge clk);
    #1;
    drive_idle();
    bus.req0_valid = 1'b1; bus.req0_a = 32'd1; bus.req0_b = 32'd2; bus.req0_aluc = 4'h0;
    @(negedge clk);
    chk("ar_accept", 32'(bus.req0_ready), 32'h1);
    @(posedge clk);
    #1;
    bus.req0_valid = 1'b0;
    chk("ar_stage1_a", bus.alu_a, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_alu_a",   bus.alu_a, 32'h0);
    chk("ar_alu_b",   bus.alu_b, 32'h0);
    chk("ar_aluc",    32'(bus.alu_aluc), 32'h0);
    chk("ar_result",  bus.resp_result, 32'h0);
    chk("ar_resp0",   32'(bus.resp0_valid), 32'h0);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("ar_nopulse0_%0d", k), 32'(bus.resp0_valid), 32'h0);
      chk($sformatf("ar_nopulse1_%0d", k), 32'(bus.resp1_valid), 32'h0);
    end
    @(posedge clk);
    #1;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    @(negedge clk);
    chk("ar_tie_ready0", 32'(bus.req0_ready), 32'h1);
    chk("ar_tie_ready1", 32'(bus.req1_ready), 32'h0);
    @(posedge clk);
    #1;
    drive_idle();
    repeat (3) @(posedge clk);

    // Streaming: eight back-to-back adds from requester 0
    for (int k = 0; k < 11; k++) begin
      @(posedge clk);
      #1;
      bus.req0_valid = (k < 8);
      bus.req0_a     = 32'(k * 3 + 1);
      bus.req0_b     = 32'(k);
      bus.req0_aluc  = 4'h0;
      @(negedge clk);
      chk($sformatf("st%0d_ready0", k), 32'(bus.req0_ready), 32'(k < 8));
      chk($sformatf("st%0d_resp0", k),  32'(bus.resp0_valid), 32'(k >= 2 && k < 10));
      chk($sformatf("st%0d_resp1", k),  32'(bus.resp1_valid), 32'h0);
      if (k >= 2 && k < 10)
        chk($sformatf("st%0d_result", k), bus.resp_result, 32'(4 * (k - 2) + 1));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 clk  input  1  single clock; all state updates on its rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 req0_valid  input  1  requester 0 has an operation pending.
REQ-004 req0_a / req0_b  input  32 each  requester 0 operands.
REQ-005 req0_aluc  input  4  requester 0 ALU operation code, same encoding as the ALU's aluc.
REQ-006 req0_ready  output  1  requester 0 operation accepted this cycle (combinational).
REQ-007 req1_valid, req1_a, req1_b, req1_aluc, req1_ready: same as REQ-003..006, for requester 1.
REQ-008 flush  input  1  synchronous kill of all in-flight operations.
REQ-009 alu_a / alu_b  output  32 each  registered operands to the shared ALU.
REQ-010 alu_aluc  output  4  registered opcode to the shared ALU.
REQ-011 alu_result  input  32  combinational result from the shared ALU.
REQ-012 resp_result  output  32  registered result returned to requesters.
REQ-013 resp0_valid / resp1_valid  output  1 each  one-cycle pulse: resp_result belongs to requester 0 / 1.

Function
REQ-014 Acceptance of requester i SHALL be the cycle where reqi_valid and reqi_ready are both 1; at most one requester is accepted per cycle.
REQ-015 reqi_ready SHALL be 0 whenever flush=1 or rst=1; otherwise ready SHALL follow the arbitration rule in REQ-016..018. Ready is independent of response state: no backpressure.
REQ-016 Single valid requester: it SHALL be granted (ready=1) the same cycle.
REQ-017 Both valid: grant SHALL go to the requester that was NOT granted at the most recent acceptance (round-robin, 1-bit last_grant register).
REQ-018 last_grant SHALL update to the accepted requester's index on every acceptance; it SHALL hold otherwise, including through flush.
REQ-019 Requesters SHALL hold operands and opcode stable while valid=1 and ready=0; the arbiter samples them only in the acceptance cycle.
REQ-020 Stage 1 (accept edge): alu_a, alu_b, alu_aluc SHALL load the granted requester's a, b, aluc; internal s1_valid SHALL be set to 1 and s1_id SHALL be set to the grant index.
REQ-021 Stage 1 with no acceptance: alu_a/alu_b/alu_aluc SHALL hold their previous values; s1_valid SHALL clear to 0.
REQ-022 Stage 2 (next edge): if s1_valid=1, resp_result SHALL load alu_result and resp{s1_id}_valid SHALL be 1 for exactly one cycle; otherwise both resp valids SHALL be 0 and resp_result SHALL hold.
REQ-023 Latency: an operation accepted in cycle N SHALL present its response in cycle N+2; throughput is one operation per cycle.
REQ-024 Back-to-back acceptances SHALL produce back-to-back response pulses, in acceptance order.
REQ-025 resp0_valid and resp1_valid SHALL never be 1 in the same cycle.
REQ-026 flush=1 at an edge:
  - s1_valid SHALL clear.
  - Both resp valids SHALL be 0 in the following cycle.
  - No acceptance occurs in that cycle.
  - A response already driven in the flush cycle itself is unaffected.
REQ-027 The arbiter SHALL NOT interpret aluc; every 4-bit code, including undefined codes, SHALL be passed through unchanged.

Reset
REQ-028 While rst=1, asynchronously and regardless of clk:
  - alu_a, alu_b, resp_result SHALL be 32'h0.
  - alu_aluc SHALL be 4'b0000.
  - resp0_valid, resp1_valid, s1_valid, s1_id SHALL be 0.
  - last_grant SHALL be 1, so requester 0 wins the first tie.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight operations; no response pulse SHALL appear after rst deasserts for operations accepted before reset.
REQ-030 First acceptance SHALL be possible in the first cycle after rst deasserts.

Verification
REQ-031 Single op: req0 a=5, b=3, aluc=0000 at cycle 1 -> req0_ready=1 at cycle 1; alu_a=5 and alu_b=3 at cycle 2; resp0_valid=1 with resp_result=8 at cycle 3; resp1_valid=0 throughout.
REQ-032 Tie after reset: both valid for 4 cycles (req0 aluc=0100 a=10 b=4; req1 aluc=0001 a=F0 b=3C) -> grants 0,1,0,1; response pulses 0,1,0,1 with results 6, 0x30, 6, 0x30.
REQ-033 Round-robin memory: req1 alone accepted, then both valid -> req0 granted first.
REQ-034 Flush: accept req1 at cycle N, assert flush at cycle N+1 -> no resp1_valid at N+2; both readys=0 during N+1; last_grant=1 preserved.
REQ-035 Async reset: rst pulsed mid-cycle with an op in stage 1 -> all outputs 0 immediately without a clock edge; no response pulse after release; next tie grants req0.
REQ-036 Streaming: req0 valid for 8 consecutive cycles, req1 idle -> 8 consecutive resp0_valid pulses starting 2 cycles after the first acceptance, results in order.
